// File: rtl/seqdet_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encoding,
// length-register width helper and the programmed-length clamp.
package seqdet_pkg;

    // FILL: fewer than len bits collected since restart; ARMED: fill == len
    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } seqdet_state_t;

    // Bits needed to hold a length value 0..pw
    function automatic int len_width(input int pw);
        return $clog2(pw + 1);
    endfunction

    // Zero-length patterns become 1 bit; over-long ones are cut to pw bits
    function automatic int clamp_len(input int raw, input int pw);
        if (raw < 1)
            return 1;
        else if (raw > pw)
            return pw;
        else
            return raw;
    endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// Saturating event counter: synchronous clear has priority over increment,
// and the count holds once it reaches all-ones.
module seqdet_sat_counter
    import seqdet_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count increment events, clear on restart, stick at the maximum value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != {CNT_W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with a runtime-programmable pattern of 1..PATTERN_W
// bits, selectable overlapping / non-overlapping detection and a registered
// one-cycle match pulse Z.
// Optional feature: define SEQDET_COUNT_EN to build the saturating match
// counter; without it match_count is tied to zero (ports are unchanged).
module seq_pattern_detector
    import seqdet_pkg::*;
#(
    parameter int                       PATTERN_W       = 8,
    parameter int                       CNT_W           = 8,
    parameter logic [PATTERN_W-1:0]     DEFAULT_PATTERN = 8'b0000_0010,
    parameter int                       DEFAULT_LEN     = 2,
    localparam int                      LEN_W           = len_width(PATTERN_W)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 I,
    input  logic                 I_valid,
    input  logic                 cfg_load,
    input  logic [PATTERN_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic                 cfg_overlap,
    output logic                 Z,
    output logic                 armed,
    output logic [CNT_W-1:0]     match_count
);

    localparam logic [LEN_W-1:0] RESET_LEN = LEN_W'(clamp_len(DEFAULT_LEN, PATTERN_W));

    logic [PATTERN_W-1:0] hist;
    logic [LEN_W-1:0]     fill;
    logic [PATTERN_W-1:0] pattern;
    logic [LEN_W-1:0]     len;
    logic                 overlap;
    seqdet_state_t        state;

    logic [PATTERN_W-1:0] hist_n;
    logic [LEN_W-1:0]     fill_n;
    logic [PATTERN_W-1:0] len_mask;
    logic                 fill_done;
    logic                 accept;
    logic                 match;

    // Next history/fill for an accepted bit and the masked pattern compare
    always_comb begin
        len_mask  = '0;
        accept    = I_valid && !cfg_load;
        hist_n    = {hist[PATTERN_W-2:0], I};
        fill_n    = (fill < len) ? fill + 1'b1 : len;
        fill_done = (fill_n == len);
        for (int k = 0; k < PATTERN_W; k++)
            len_mask[k] = (k < int'(len));
        match     = accept && fill_done && (((hist_n ^ pattern) & len_mask) == '0);
    end

    // Configuration, history, fill level, FILL/ARMED state and match pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist    <= '0;
            fill    <= '0;
            pattern <= DEFAULT_PATTERN;
            len     <= RESET_LEN;
            overlap <= 1'b1;
            state   <= FILL;
            Z       <= 1'b0;
        end else if (cfg_load) begin
            pattern <= cfg_pattern;
            len     <= LEN_W'(clamp_len(int'(cfg_len), PATTERN_W));
            overlap <= cfg_overlap;
            hist    <= '0;
            fill    <= '0;
            state   <= FILL;
            Z       <= 1'b0;
        end else if (I_valid) begin
            hist <= hist_n;
            Z    <= match;
            if (match && !overlap) begin
                // History is kept, but a full len bits must arrive again
                fill  <= '0;
                state <= FILL;
            end else begin
                fill  <= fill_n;
                state <= fill_done ? ARMED : FILL;
            end
        end else begin
            Z <= 1'b0;
        end
    end

    assign armed = (state == ARMED);

`ifdef SEQDET_COUNT_EN
    seqdet_sat_counter #(
        .CNT_W (CNT_W)
    ) u_count (
        .clk   (clk),
        .reset (reset),
        .clr   (cfg_load),
        .inc   (match),
        .count (match_count)
    );
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector: the stimulus process pushes the
// hand-computed per-cycle expectation; a monitor pops and compares after
// each rising edge. A second instance with CNT_W=2 covers saturation.
module tb_seq_pattern_detector;

    localparam int PW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          I = 1'b0;
    logic          I_valid = 1'b0;
    logic          cfg_load = 1'b0;
    logic [PW-1:0] cfg_pattern = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          cfg_overlap = 1'b1;
    logic          Z, armed, Z2, armed2;
    logic [7:0]    match_count;
    logic [1:0]    match_count2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int    z;
        int    a;
        int    c;
        bit    chk2;
        int    c2;
        string nm;
    } exp_t;

    exp_t q[$];

    seq_pattern_detector #(.PATTERN_W(PW), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .I(I), .I_valid(I_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .Z(Z), .armed(armed), .match_count(match_count)
    );

    seq_pattern_detector #(.PATTERN_W(PW), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .I(I), .I_valid(I_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .Z(Z2), .armed(armed2), .match_count(match_count2)
    );

    always #5 clk = ~clk;

    // Counter value that the build is expected to show
    function automatic int cexp(input int x);
`ifdef SEQDET_COUNT_EN
        return x;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Monitor: the DUT presents Z/armed/match_count after every edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.nm, "/Z"}, int'(Z), e.z);
                chk({e.nm, "/armed"}, int'(armed), e.a);
                chk({e.nm, "/count"}, int'(match_count), cexp(e.c));
                if (e.chk2) begin
                    chk({e.nm, "/Z2"}, int'(Z2), e.z);
                    chk({e.nm, "/count2"}, int'(match_count2), cexp(e.c2));
                end
            end
        end
    end

    task automatic push(input int z, input int a, input int c, input string nm,
                        input bit c2en = 1'b0, input int c2 = 0);
        exp_t e;
        e.z = z; e.a = a; e.c = c; e.chk2 = c2en; e.c2 = c2; e.nm = nm;
        q.push_back(e);
    endtask

    // One cycle of serial input with its expected registered result
    task automatic step(input bit b, input bit v, input int z, input int a, input int c,
                        input string nm, input bit c2en = 1'b0, input int c2 = 0);
        @(negedge clk);
        cfg_load = 1'b0;
        I        = b;
        I_valid  = v;
        push(z, a, c, nm, c2en, c2);
    endtask

    // Configuration load cycle; optional simultaneous I_valid must be ignored
    task automatic load(input logic [PW-1:0] pat, input int ln, input bit ov,
                        input string nm, input bit v = 1'b0, input bit b = 1'b0);
        @(negedge clk);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = LW'(ln);
        cfg_overlap = ov;
        I_valid     = v;
        I           = b;
        push(0, 0, 0, nm, 1'b1, 0);
    endtask

    // Asynchronous reset between edges, outputs checked before any edge
    task automatic do_reset(input string nm);
        @(negedge clk);
        cfg_load = 1'b0;
        I_valid  = 1'b0;
        reset    = 1'b0;
        #2;
        chk({nm, "/Z"}, int'(Z), 0);
        chk({nm, "/armed"}, int'(armed), 0);
        chk({nm, "/count"}, int'(match_count), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset("rst0");

        // Reset defaults: pattern "10", overlap
        step(1, 1, 0, 0, 0, "d.b1");
        step(1, 1, 0, 1, 0, "d.b2");
        step(0, 1, 1, 1, 1, "d.b3");
        step(0, 1, 0, 1, 1, "d.b4");
        step(1, 1, 0, 1, 1, "d.b5");
        step(0, 1, 1, 1, 2, "d.b6");
        step(0, 0, 0, 1, 2, "d.idle");

        // 1011, overlapping
        load(8'b1011, 4, 1'b1, "ov.load");
        step(1, 1, 0, 0, 0, "ov.b1");
        step(0, 1, 0, 0, 0, "ov.b2");
        step(1, 1, 0, 0, 0, "ov.b3");
        step(1, 1, 1, 1, 1, "ov.b4");
        step(0, 1, 0, 1, 1, "ov.b5");
        step(1, 1, 0, 1, 1, "ov.b6");
        step(1, 1, 1, 1, 2, "ov.b7");

        // 1011, non-overlapping
        load(8'b1011, 4, 1'b0, "no.load");
        step(1, 1, 0, 0, 0, "no.b1");
        step(0, 1, 0, 0, 0, "no.b2");
        step(1, 1, 0, 0, 0, "no.b3");
        step(1, 1, 1, 0, 1, "no.b4");
        step(0, 1, 0, 0, 1, "no.b5");
        step(1, 1, 0, 0, 1, "no.b6");
        step(1, 1, 0, 0, 1, "no.b7");

        // "10" with an I_valid gap
        load(8'b10, 2, 1'b1, "gap.load");
        step(1, 1, 0, 0, 0, "gap.b1");
        step(0, 0, 0, 0, 0, "gap.i1");
        step(0, 0, 0, 0, 0, "gap.i2");
        step(0, 0, 0, 0, 0, "gap.i3");
        step(0, 1, 1, 1, 1, "gap.b2");
        step(0, 0, 0, 1, 1, "gap.i4");

        // Single-bit pattern "1": back-to-back pulses, 2-bit counter saturates
        load(8'b1, 1, 1'b1, "sat.load");
        step(1, 1, 1, 1, 1, "sat.b1", 1'b1, 1);
        step(1, 1, 1, 1, 2, "sat.b2", 1'b1, 2);
        step(1, 1, 1, 1, 3, "sat.b3", 1'b1, 3);
        step(1, 1, 1, 1, 4, "sat.b4", 1'b1, 3);
        step(1, 1, 1, 1, 5, "sat.b5", 1'b1, 3);
        step(0, 1, 0, 1, 5, "sat.b6", 1'b1, 3);
        step(0, 0, 0, 1, 5, "sat.idle", 1'b1, 3);

        // Reset while armed with a nonzero count
        do_reset("rst1");

        // Reset mid-pattern: progress lost, defaults ("10") back in force
        load(8'b1011, 4, 1'b1, "mid.load");
        step(1, 1, 0, 0, 0, "mid.b1");
        step(0, 1, 0, 0, 0, "mid.b2");
        step(1, 1, 0, 0, 0, "mid.b3");
        do_reset("rst2");
        step(1, 1, 0, 0, 0, "mid.b4");
        step(0, 1, 1, 1, 1, "mid.b5");

        // cfg_len=0 is clamped to 1
        load(8'b1, 0, 1'b1, "cl.load");
        step(1, 1, 1, 1, 1, "cl.b1");
        step(0, 1, 0, 1, 1, "cl.b2");
        step(1, 1, 1, 1, 2, "cl.b3");

        // cfg_load with I_valid: the bit is dropped
        load(8'b01, 2, 1'b1, "ig.load", 1'b1, 1'b0);
        step(0, 0, 0, 0, 0, "ig.idle");
        step(1, 1, 0, 0, 0, "ig.b1");
        step(0, 1, 0, 1, 0, "ig.b2");
        step(1, 1, 1, 1, 1, "ig.b3");

        @(negedge clk);
        I_valid = 1'b0;
        for (int n = 0; n < 10 && q.size() > 0; n++)
            @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial pattern detector. It accepts one qualified bit per cycle and pulses a registered match flag whenever the most recent bits equal a runtime-programmable pattern of 1..PATTERN_W bits. Overlapping or non-overlapping detection is selectable, and an optional saturating match counter can be compiled in. It sits between a serial input front end and the control logic that consumes detection events; the reset defaults reproduce the team's existing "10" detector.

## Interface
- PATTERN_W, 8, maximum pattern length in bits; must be ≥2.
- CNT_W, 8, width of match_count.
- DEFAULT_PATTERN, 8'b0000_0010, pattern loaded at reset; right-aligned.
- DEFAULT_LEN, 2, pattern length loaded at reset.
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- I  input  1  serial data bit.
- I_valid  input  1  I is accepted on cycles where this is high.
- cfg_load  input  1  latch cfg_pattern, cfg_len and cfg_overlap; restart detection.
- cfg_pattern  input  PATTERN_W  pattern; bit cfg_len-1 is the first bit received, bit 0 the last.
- cfg_len  input  LEN_W = $clog2(PATTERN_W+1)  pattern length.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- Z  output  1  registered match pulse.
- armed  output  1  high when at least len bits have been accepted since the last restart.
- match_count  output  CNT_W  saturating count of matches.

## Operation
- Registers:
  - hist[PATTERN_W-1:0]: shift history.
  - fill[LEN_W-1:0]: saturates at len.
  - Active pattern, len and overlap registers.
  - Z, and match_count.
- Reset (async, reset==0):
  - hist=0, fill=0, Z=0, armed=0, match_count=0.
  - pattern=DEFAULT_PATTERN, len=DEFAULT_LEN, overlap=1.
- cfg_load high:
  - Latch the configuration; clear hist, fill, Z and match_count.
  - I_valid on that cycle is ignored.
  - cfg_load has priority over I_valid.
- Length clamp: cfg_len=0 is stored as 1; cfg_len>PATTERN_W is stored as PATTERN_W.
- Accepted bit (I_valid=1, cfg_load=0):
  - hist_n = {hist[PATTERN_W-2:0], I}.
  - fill_n = min(fill+1, len).
  - match = (fill_n==len) && (hist_n[len-1:0]==pattern[len-1:0]); compare only the low len bits.
- On match:
  - Z<=1.
  - match_count increments unless already all-ones.
  - If overlap=0, fill<=0; history bits are kept but are not eligible until refilled.
  - If overlap=1, fill stays at len.
- Z<=0 on every cycle without a match, including cycles with I_valid=0.
- FSM, derived from fill:
  - FILL (fill<len) → ARMED when fill_n==len.
  - ARMED → FILL on a non-overlap match, on cfg_load, or on reset.
  - armed = (state==ARMED).

## Timing
- Latency: Z is high in the cycle immediately after the edge that accepted the completing bit. It is high for exactly one cycle per match.
- Back-to-back matches (overlap=1 with a periodic pattern, or len=1) hold Z high for consecutive cycles.
- match_count updates on the same edge as Z.
- Gaps in I_valid do not break a pattern; only accepted bits shift.
- Reset asserted mid-pattern clears all progress immediately (asynchronously). The first bit accepted after reset release starts a new fill.

## Configuration
- Macro SEQDET_COUNT_EN.
- Defined: match_count behaves as specified above.
- Undefined:
  - The counter logic is removed.
  - match_count is tied to 0.
  - The port list is unchanged.

## Structure
- Shared package seqdet_pkg holds:
  - FSM state encoding (FILL, ARMED).
  - The LEN_W computation helper.
  - The length-clamp function.
- Sub-module seqdet_sat_counter (parameter CNT_W; inputs clk, reset, clr, inc; output count). It is instantiated only under SEQDET_COUNT_EN.

## Test plan
- Reset defaults, stream 1,1,0,0,1,0 → Z pulses the cycle after bits 3 and 6; match_count=2.
- Load 4'b1011, len 4, overlap=1, stream 1,0,1,1,0,1,1 → Z after bits 4 and 7; count 2. Same stream with overlap=0 → Z after bit 4 only; count 1.
- Defaults, bits 1 and 0 separated by 3 cycles of I_valid=0 → single one-cycle Z after the 0; armed is high from the 2nd accepted bit.
- CNT_W=2, pattern len 1 = 1, 5 accepted 1s → Z high for 5 consecutive cycles; match_count saturates at 3.
- Load 4'b1011, accept 1,0,1, assert reset, release, accept 1 → no Z; after reset the pattern is the default "10".
- cfg_len=0 with cfg_pattern bit0=1 → stored len=1; every accepted 1 produces Z. cfg_load together with I_valid → bit ignored; hist and fill stay 0.
